// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard unit: forwarding selects,
// hazard FSM states and the width of the sequence down-counter.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_STALL = 2'b01,
        S_FLUSH = 2'b10
    } haz_state_t;

    localparam int CNT_W = 3;

endpackage

// File: rtl/pipe_hazard_unit_fwd_match.sv
// Per-operand dependency compare: picks the forwarding source and reports
// a raw EX-destination hit used by the load-use and branch hazard checks.
module fwd_match
    import pipe_pkg::*;
#(
    parameter int RA_W     = 3,
    parameter int ZERO_REG = 1
) (
    input  logic [RA_W-1:0] i_rs,
    input  logic            i_use,
    input  logic [RA_W-1:0] i_ex_rd,
    input  logic            i_ex_we,
    input  logic            i_ex_is_ld,
    input  logic [RA_W-1:0] i_mem_rd,
    input  logic            i_mem_we,
    output logic [1:0]      o_sel,
    output logic            o_ex_hit
);

    logic     w_ex_zero;
    logic     w_mem_zero;
    logic     w_mem_hit;
    fwd_sel_t w_sel;

    assign w_ex_zero  = (ZERO_REG != 0) && (i_ex_rd == '0);
    assign w_mem_zero = (ZERO_REG != 0) && (i_mem_rd == '0);

    // Hit ignores the write enable so the caller can qualify it per hazard
    assign o_ex_hit  = i_use && (i_rs == i_ex_rd) && !w_ex_zero;
    assign w_mem_hit = i_use && i_mem_we && (i_rs == i_mem_rd) && !w_mem_zero;

    always_comb begin
        w_sel = FWD_RF;
        if (o_ex_hit && i_ex_we && !i_ex_is_ld)
            w_sel = FWD_EX;
        else if (w_mem_hit)
            w_sel = FWD_MEM;
    end

    assign o_sel = w_sel;

endmodule

// File: rtl/pipe_hazard_unit.sv
// Forwarding select, load-use/branch stall and taken-branch flush control.
// Define PIPE_HAZARD_STATS_EN to add saturating stall/flush cycle counters.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int RA_W      = 3,
    parameter int LOAD_LAT  = 1,
    parameter int FLUSH_CYC = 1,
    parameter int ZERO_REG  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            id_use1,
    input  logic            id_use2,
    input  logic            id_is_br,
    input  logic            ex_we,
    input  logic            ex_is_ld,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            mem_we,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            br_taken,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            stall,
    output logic            flush
`ifdef PIPE_HAZARD_STATS_EN
    ,
    output logic [15:0]     stall_cnt,
    output logic [15:0]     flush_cnt
`endif
);

    localparam logic [CNT_W-1:0] FL_INIT =
        (FLUSH_CYC > 1) ? CNT_W'(FLUSH_CYC - 2) : '0;
    localparam logic [CNT_W-1:0] LD_INIT =
        (LOAD_LAT > 1) ? CNT_W'(LOAD_LAT - 2) : '0;
    localparam haz_state_t FL_NEXT = (FLUSH_CYC > 1) ? S_FLUSH : S_RUN;
    localparam haz_state_t LD_NEXT = (LOAD_LAT > 1) ? S_STALL : S_RUN;

    logic             w_hit_a;
    logic             w_hit_b;
    logic             w_lu;
    logic             w_bd;
    haz_state_t       r_state;
    haz_state_t       w_nstate;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_ncnt;

    fwd_match #(.RA_W(RA_W), .ZERO_REG(ZERO_REG)) u_fwd_a (
        .i_rs       (id_rs1),
        .i_use      (id_use1),
        .i_ex_rd    (ex_rd),
        .i_ex_we    (ex_we),
        .i_ex_is_ld (ex_is_ld),
        .i_mem_rd   (mem_rd),
        .i_mem_we   (mem_we),
        .o_sel      (fwd_a),
        .o_ex_hit   (w_hit_a)
    );

    fwd_match #(.RA_W(RA_W), .ZERO_REG(ZERO_REG)) u_fwd_b (
        .i_rs       (id_rs2),
        .i_use      (id_use2),
        .i_ex_rd    (ex_rd),
        .i_ex_we    (ex_we),
        .i_ex_is_ld (ex_is_ld),
        .i_mem_rd   (mem_rd),
        .i_mem_we   (mem_we),
        .o_sel      (fwd_b),
        .o_ex_hit   (w_hit_b)
    );

    assign w_lu = id_valid && ex_is_ld && (w_hit_a || w_hit_b);
    assign w_bd = id_valid && id_is_br && ex_we && !ex_is_ld
                  && (w_hit_a || w_hit_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
        end
    end

    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        stall    = 1'b0;
        flush    = 1'b0;
        unique case (r_state)
            S_RUN: begin
                if (br_taken) begin
                    flush    = 1'b1;
                    w_nstate = FL_NEXT;
                    w_ncnt   = FL_INIT;
                end else if (w_lu) begin
                    stall    = 1'b1;
                    w_nstate = LD_NEXT;
                    w_ncnt   = LD_INIT;
                end else if (w_bd) begin
                    stall = 1'b1;
                end
            end
            S_STALL: begin
                // A taken branch kills the stalled instruction outright
                if (br_taken) begin
                    flush    = 1'b1;
                    w_nstate = FL_NEXT;
                    w_ncnt   = FL_INIT;
                end else begin
                    stall = 1'b1;
                    if (r_cnt == '0)
                        w_nstate = S_RUN;
                    else
                        w_ncnt = r_cnt - 1'b1;
                end
            end
            S_FLUSH: begin
                flush = 1'b1;
                if (r_cnt == '0)
                    w_nstate = S_RUN;
                else
                    w_ncnt = r_cnt - 1'b1;
            end
            default: begin
                w_nstate = S_RUN;
                w_ncnt   = '0;
            end
        endcase
    end

`ifdef PIPE_HAZARD_STATS_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (flush && (r_flush_cnt != 16'hFFFF))
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 Parameter RA_W, default 3, register-address width (2**RA_W architectural registers).
REQ-002 Parameter LOAD_LAT, default 1, range 1..7, number of load-use stall cycles.
REQ-003 Parameter FLUSH_CYC, default 1, range 1..7, number of flush cycles after a taken branch.
REQ-004 Parameter ZERO_REG, default 1, where 1 means register 0 is hardwired and never forwarded or matched.
REQ-005 Ports, in order: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset; the block shall use this one clock only.
REQ-006 id_valid in 1, ID stage holds a real instruction.
REQ-007 id_rs1 and id_rs2 in RA_W, ID source registers.
REQ-008 id_use1 and id_use2 in 1, the corresponding source is read.
REQ-009 id_is_br in 1, ID instruction is a conditional branch.
REQ-010 ex_we in 1, EX instruction writes a register.
REQ-011 ex_is_ld in 1, EX instruction is a load.
REQ-012 ex_rd in RA_W, EX destination register.
REQ-013 mem_we in 1 and mem_rd in RA_W, MEM stage write-enable and destination register.
REQ-014 br_taken in 1, the branch resolving this cycle is taken.
REQ-015 fwd_a and fwd_b out 2, operand source select: 00 regfile, 01 EX result, 10 MEM result.
REQ-016 stall out 1, hold PC and IF/ID, and insert a bubble into EX.
REQ-017 flush out 1, squash IF and ID.

Function
REQ-018 The match function m(rs,use,rd,we) shall be use AND we AND (rs==rd) AND NOT(ZERO_REG AND rd==0).
REQ-019 fwd_a shall be combinational: 01 if m(id_rs1,id_use1,ex_rd,ex_we) and not ex_is_ld; otherwise 10 if m(id_rs1,id_use1,mem_rd,mem_we); otherwise 00. fwd_b shall use the same rule with id_rs2/id_use2. EX shall have priority over MEM.
REQ-020 The FSM shall have three states: RUN, STALL, FLUSH, with a 3-bit down-counter cnt.
REQ-021 A load-use hazard (lu) shall be id_valid AND ex_is_ld AND (m(id_rs1,id_use1,ex_rd,1) OR m(id_rs2,id_use2,ex_rd,1)).
REQ-022 A branch-data hazard (bd) shall be id_valid AND id_is_br AND ex_we AND NOT ex_is_ld AND an EX match on either source; it shall cause exactly one stall cycle.
REQ-023 In RUN with br_taken: flush=1 and stall=0 this cycle. If FLUSH_CYC>1, the FSM shall go to FLUSH with cnt=FLUSH_CYC-2; otherwise it shall stay in RUN.
REQ-024 In RUN with lu (and no br_taken): stall=1. If LOAD_LAT>1, the FSM shall go to STALL with cnt=LOAD_LAT-2; otherwise it shall stay in RUN.
REQ-025 In RUN with bd (and no br_taken or lu): stall=1 and the FSM shall stay in RUN.
REQ-026 In STALL: stall=1. If cnt==0 the FSM shall go to RUN, otherwise it shall decrement cnt. If br_taken occurs in STALL, flush shall take over per REQ-023 and stall shall drop to 0.
REQ-027 In FLUSH: flush=1 and stall=0; br_taken and lu shall be ignored. If cnt==0 the FSM shall go to RUN, otherwise it shall decrement cnt.
REQ-028 Precedence for simultaneous events shall be: br_taken > lu > bd. stall and flush shall never both be 1.
REQ-029 stall and flush shall be Moore/Mealy combinational from the state plus the current inputs, with zero-cycle latency.

Reset
REQ-030 On rst=1, asynchronously: state=RUN, cnt=0; stall and flush shall be 0 when no hazard is present.
REQ-031 Reset asserted mid-STALL or mid-FLUSH shall abort that sequence immediately; the first cycle after release shall be evaluated as RUN.

Configuration
REQ-032 Macro PIPE_HAZARD_STATS_EN, when defined, shall add outputs stall_cnt out 16 and flush_cnt out 16.
REQ-033 stall_cnt and flush_cnt shall count cycles with stall=1 and flush=1 respectively, saturate at 16'hFFFF, and reset to 0.
REQ-034 When PIPE_HAZARD_STATS_EN is undefined, these ports and counters shall not exist.

Structure
REQ-035 Package pipe_pkg shall hold the fwd_sel_t encoding (FWD_RF=00, FWD_EX=01, FWD_MEM=10) and the haz_state_t enum.
REQ-036 The forwarding compare logic shall be one sub-module, fwd_match, instantiated per source operand; the FSM shall stay in the top module.

Verification
REQ-037 Scenario: ex_we=1, ex_rd=3, id_rs1=3, id_use1=1, mem_we=1, mem_rd=3 -> fwd_a=01; with ex_we=0 -> fwd_a=10.
REQ-038 Scenario: ZERO_REG=1, ex_rd=0, id_rs2=0, ex_we=1 -> fwd_b=00 and no stall.
REQ-039 Scenario: LOAD_LAT=3, ex_is_ld=1, ex_rd=5, id_rs1=5 -> stall=1 for exactly 3 cycles, then 0.
REQ-040 Scenario: branch in ID with source 2, ALU writes r2 in EX -> stall for 1 cycle; next cycle with ex_we=0 -> stall=0.
REQ-041 Scenario: FLUSH_CYC=2, br_taken and lu in the same cycle -> flush=1 for 2 cycles, stall=0 throughout.
REQ-042 Scenario: rst pulsed during the second STALL cycle -> stall=0 after reset with no hazard inputs; with PIPE_HAZARD_STATS_EN defined, stall_cnt=0.
